riscv_pipe_ctrl: RTL
====================

// Module: riscv_pipe_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  Watches ID source indices, the EX-stage load/branch status and the MEM-stage data-memory handshake.
//  Drives per-stage stall and flush strobes to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Owns the memory-wait FSM and a bus-timeout watchdog.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles MEM may wait for mem_ack_i before error (>=2)
//  CNT_W        32  width of optional performance counters
// PORTS
//  clk            in   1  pipeline clock
//  rst_n          in   1  asynchronous active-low reset
//  id_valid_i     in   1  ID holds a real instruction
//  id_rs1_idx_i   in   5  ID rs1 index
//  id_rs2_idx_i   in   5  ID rs2 index
//  ex_data_re_i   in   1  EX instruction is a load
//  ex_rd_idx_i    in   5  EX destination index
//  ex_br_taken_i  in   1  EX branch/jal resolved taken
//  mem_req_i      in   1  MEM instruction accesses data memory (load or store)
//  mem_ack_i      in   1  data memory completes access this cycle
//  pc_stall_o     out  1  hold PC
//  if_id_stall_o  out  1  hold IF/ID
//  if_id_flush_o  out  1  load NOP into IF/ID
//  id_ex_flush_o  out  1  load bubble into ID/EX
//  ex_mem_stall_o out  1  hold EX/MEM
//  mem_wb_flush_o out  1  load bubble into MEM/WB
//  err_o          out  1  sticky bus-timeout error
//  stall_cnt_o    out  CNT_W  stall cycles (RISCV_PIPE_PERF_EN only)
//  flush_cnt_o    out  CNT_W  taken-branch flushes (RISCV_PIPE_PERF_EN only)
// BEHAVIOUR
//  - Reset: asynchronous. State = S_RUN; wait counter = 0; err_o = 0; counters = 0.
//  - Outputs: combinational from state and inputs. With no hazard, all outputs are 0.
//  - FSM (registered on clk rising edge):
//    S_RUN  -> S_WAIT when mem_req_i && !mem_ack_i.
//    S_WAIT -> S_RUN on mem_ack_i.
//    S_WAIT -> S_ERR when wait count == MEM_TIMEOUT-1 and !mem_ack_i.
//    S_ERR: terminal until reset.
//  - Memory wait (S_RUN with mem_req_i && !mem_ack_i, or S_WAIT with !mem_ack_i):
//    pc/if_id/ex_mem stall = 1; id_ex_flush = 0 (ID/EX frozen by the stall); mem_wb_flush = 1.
//    This condition has highest priority and masks branch and load-use actions.
//  - Wait counter:
//    Cleared on entry to S_WAIT and on return to S_RUN; increments each S_WAIT cycle.
//    Saturates; never wraps.
//    An ack in the same cycle as the timeout compare wins: go to S_RUN, no error.
//  - Taken branch (no memory wait): if_id_flush = 1 and id_ex_flush = 1 for exactly one cycle; no stalls.
//    Branch overrides load-use (the dependent ID instruction is squashed).
//  - Branch held in EX during a memory wait is acted on in the cycle mem_ack_i arrives.
//  - Load-use: id_valid_i && ex_data_re_i && ex_rd_idx_i != 0 && (ex_rd_idx_i == id_rs1_idx_i || == id_rs2_idx_i).
//    Response: pc_stall = if_id_stall = 1, id_ex_flush = 1 for one cycle. x0 never creates a hazard.
//  - S_ERR: pc/if_id/ex_mem stall = 1, id_ex_flush = 1, mem_wb_flush = 1, err_o = 1. Core frozen.
//  - Reset mid-wait: FSM returns to S_RUN immediately and err_o clears; the pending memory access is abandoned.
// CONFIGURATION
//  RISCV_PIPE_PERF_EN defined:
//    stall_cnt_o increments in each cycle pc_stall_o = 1.
//    flush_cnt_o increments in each cycle a taken-branch flush is issued.
//    Both counters wrap modulo 2^CNT_W and reset to 0.
//  RISCV_PIPE_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.
// TESTING
//  1. lw x5 in EX, ID rs1 = 5, id_valid = 1 -> pc_stall = if_id_stall = id_ex_flush = 1 for 1 cycle, then 0.
//  2. Load to x0 in EX, ID rs2 = 0 -> no stall, no flush.
//  3. ex_br_taken = 1 together with a load-use match -> if_id_flush = id_ex_flush = 1, pc_stall = 0.
//  4. mem_req = 1, ack after 3 cycles -> 3 stall cycles, mem_wb_flush = 1 for those cycles, back to S_RUN, err_o = 0.
//  5. mem_req = 1, no ack, MEM_TIMEOUT = 16 -> err_o = 1 after 16 wait cycles and stays 1; rst_n low clears it.
//  6. PERF_EN: 2 load-use stalls + 1 taken branch -> stall_cnt_o = 2, flush_cnt_o = 1.

Source files
------------

// File: rtl/riscv_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use, taken-branch and
// data-memory wait handling with a bus-timeout watchdog. Optional counters: RISCV_PIPE_PERF_EN.
module riscv_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_idx_i,
    input  logic [4:0]       id_rs2_idx_i,
    input  logic             ex_data_re_i,
    input  logic [4:0]       ex_rd_idx_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic             mem_wb_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WCNT_W-1:0] wait_cnt_reg;

    logic [9:0] src_idx_flat;
    logic [1:0] src_hit;
    logic       load_use;
    logic       mem_wait;
    logic       in_err;
    logic       br_flush;

    assign src_idx_flat = {id_rs2_idx_i, id_rs1_idx_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_hit
            assign src_hit[gi] = (src_idx_flat[gi*5 +: 5] == ex_rd_idx_i);
        end
    endgenerate

    // x0 is hard-wired zero, so a load targeting it never produces a usable result to wait for.
    assign load_use = id_valid_i && ex_data_re_i && (ex_rd_idx_i != 5'd0) && (|src_hit);

    assign in_err   = (state_reg == S_ERR);
    assign mem_wait = ((state_reg == S_RUN)  && mem_req_i && !mem_ack_i) ||
                      ((state_reg == S_WAIT) && !mem_ack_i);
    assign br_flush = ex_br_taken_i && !mem_wait && !in_err;

    // Priority: bus error, then memory wait, then taken branch, then load-use.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (in_err) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mem_wait) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (br_flush) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end
    end

    assign err_o = in_err;

    // The counter never passes WCNT_LAST: reaching it without an ack leaves S_WAIT for S_ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RUN;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        state_reg    <= S_RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WCNT_LAST) begin
                        state_reg    <= S_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_ERR: begin
                    state_reg <= S_ERR;
                end
                default: begin
                    state_reg    <= S_RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

`ifdef RISCV_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (pc_stall_o) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (br_flush) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
